// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the Harvard MIPS core fetch path:
//   - fetch_state_t : fetch sequencer states
//   - MIPS_RESET_VECTOR / MIPS_HALT_ADDR : defaults for the fetch unit
//   - INSTR_BYTES : size of one instruction word in bytes
//   - is_word_aligned() : checks the two address LSBs of a branch target
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    SLOT   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] MIPS_HALT_ADDR    = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES       = 32'd4;

  // Instruction fetches must be word aligned: both low address bits clear.
  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/mips_fetch_unit_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter: counts inc_i pulses and sticks at all-ones.
// Cleared only by the asynchronous active-low reset.
// Ports:
//   clk     in  1  clock, rising edge
//   rst_n   in  1  asynchronous active-low clear
//   inc_i   in  1  increment request for this cycle
//   count_o out W  current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// mips_fetch_unit
// Program counter and fetch sequencer for the Harvard MIPS core. Handles
// branch-delay-slot redirection, halting on a jump to HALT_ADDR, global
// clk_enable pause, stall hold, misaligned-target fault and a saturating
// retired-instruction counter.
// Ports:
//   clk            in  1        system clock, rising edge
//   reset          in  1        asynchronous active-low reset
//   clk_enable     in  1        0 = all state holds
//   stall          in  1        1 = hold PC/state, no retire
//   branch_valid   in  1        instruction at PC is a taken branch/jump
//   branch_target  in  ADDR_W   its destination
//   instr_address  out ADDR_W   current PC
//   instr_valid    out 1        instruction at PC is executed
//   in_delay_slot  out 1        instruction at PC is a delay-slot instruction
//   link_address   out ADDR_W   PC+8 (valid in RUN)
//   active         out 1        core running (RUN or SLOT)
//   fault          out 1        sticky misaligned-target flag
//   retired_count  out COUNT_W  saturating retired-instruction count
// ---------------------------------------------------------------------------
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = MIPS_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = MIPS_HALT_ADDR,
  parameter int          COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic               stall,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  instr_address,
  output logic               instr_valid,
  output logic               in_delay_slot,
  output logic [ADDR_W-1:0]  link_address,
  output logic               active,
  output logic               fault,
  output logic [COUNT_W-1:0] retired_count
);

  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] HALT_PC = ADDR_W'(HALT_ADDR);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] LINK    = ADDR_W'(2 * INSTR_BYTES);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              fault_q, fault_d;
  logic              adv_s;
  logic              retire_s;
  logic [ADDR_W-1:0] pc_inc_s;

  assign adv_s    = clk_enable & ~stall;
  assign pc_inc_s = pc_q + STEP;

  // Next-state, PC, target and retire decision.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    fault_d  = fault_q;
    retire_s = 1'b0;
    case (state_q)
      BOOT: begin
        // Stall does not block leaving BOOT; only clk_enable does.
        if (clk_enable) begin
          state_d = RUN;
        end else begin
          state_d = BOOT;
        end
      end
      RUN: begin
        if (adv_s) begin
          if (branch_valid) begin
            if (!is_word_aligned(branch_target[1:0])) begin
              // Faulting branch is not retired and the PC freezes on it.
              fault_d = 1'b1;
              state_d = HALTED;
            end else begin
              target_d = branch_target;
              pc_d     = pc_inc_s;
              retire_s = 1'b1;
              state_d  = SLOT;
            end
          end else begin
            pc_d     = pc_inc_s;
            retire_s = 1'b1;
          end
        end else begin
          state_d = RUN;
        end
      end
      SLOT: begin
        // branch_valid is deliberately ignored here.
        if (adv_s) begin
          retire_s = 1'b1;
          pc_d     = target_q;
          if (target_q == HALT_PC) begin
            state_d = HALTED;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = SLOT;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  // Sequencer registers; everything freezes while clk_enable is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= BOOT;
      pc_q     <= RST_PC;
      target_q <= {ADDR_W{1'b0}};
      fault_q  <= 1'b0;
    end else if (clk_enable) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      fault_q  <= fault_d;
    end else begin
      state_q  <= state_q;
      pc_q     <= pc_q;
      target_q <= target_q;
      fault_q  <= fault_q;
    end
  end

  // retire_s already implies clk_enable, so the counter needs no extra gate.
  sat_counter #(
    .W (COUNT_W)
  ) u_retired (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (retire_s),
    .count_o (retired_count)
  );

  // Status outputs decoded straight from the state register.
  always_comb begin
    active        = 1'b0;
    instr_valid   = 1'b0;
    in_delay_slot = 1'b0;
    link_address  = {ADDR_W{1'b0}};
    case (state_q)
      RUN: begin
        active       = 1'b1;
        instr_valid  = 1'b1;
        link_address = pc_q + LINK;
      end
      SLOT: begin
        active        = 1'b1;
        instr_valid   = 1'b1;
        in_delay_slot = 1'b1;
      end
      BOOT, HALTED: begin
        active      = 1'b0;
        instr_valid = 1'b0;
      end
      default: begin
        active      = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  assign instr_address = pc_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_unit
// Directed self-checking bench. Each step drives inputs, pushes the expected
// post-edge outputs to a scoreboard queue, and pops/compares them #1 after
// the clock edge.
// ---------------------------------------------------------------------------
module tb_mips_fetch_unit;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        stall;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [31:0] instr_address;
  logic        instr_valid;
  logic        in_delay_slot;
  logic [31:0] link_address;
  logic        active;
  logic        fault;
  logic [31:0] retired_count;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic        valid;
    logic        act;
    logic        slot;
    logic        flt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  mips_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .instr_address (instr_address),
    .instr_valid   (instr_valid),
    .in_delay_slot (in_delay_slot),
    .link_address  (link_address),
    .active        (active),
    .fault         (fault),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] a, input logic v,
                          input logic ac, input logic s, input logic f, input logic [31:0] c);
    exp_t e;
    e.tag = tag; e.addr = a; e.valid = v; e.act = ac; e.slot = s; e.flt = f; e.cnt = c;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, ".addr"},  instr_address,         e.addr);
      chk({e.tag, ".valid"}, {31'd0, instr_valid},   {31'd0, e.valid});
      chk({e.tag, ".act"},   {31'd0, active},        {31'd0, e.act});
      chk({e.tag, ".slot"},  {31'd0, in_delay_slot}, {31'd0, e.slot});
      chk({e.tag, ".fault"}, {31'd0, fault},         {31'd0, e.flt});
      chk({e.tag, ".cnt"},   retired_count,          e.cnt);
    end
  endtask

  task automatic step(input string tag, input logic ce, input logic st, input logic bv,
                      input logic [31:0] tgt, input logic [31:0] a, input logic v,
                      input logic ac, input logic s, input logic f, input logic [31:0] c);
    clk_enable    = ce;
    stall         = st;
    branch_valid  = bv;
    branch_target = tgt;
    push_exp(tag, a, v, ac, s, f, c);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic check_now(input string tag, input logic [31:0] a, input logic v,
                           input logic ac, input logic s, input logic f, input logic [31:0] c);
    push_exp(tag, a, v, ac, s, f, c);
    pop_check();
  endtask

  initial begin
    reset         = 1'b0;
    clk_enable    = 1'b1;
    stall         = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 32'h0;
    #12;
    check_now("reset", 32'hBFC00000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b1;

    // Boot and straight-line execution.
    step("boot", 1'b1, 1'b0, 1'b0, 32'h0, 32'hBFC00000, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step("run1", 1'b1, 1'b0, 1'b0, 32'h0, 32'hBFC00004, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1);
    step("run2", 1'b1, 1'b0, 1'b0, 32'h0, 32'hBFC00008, 1'b1, 1'b1, 1'b0, 1'b0, 32'd2);
    step("run3", 1'b1, 1'b0, 1'b0, 32'h0, 32'hBFC0000C, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3);
    step("run4", 1'b1, 1'b0, 1'b0, 32'h0, 32'hBFC00010, 1'b1, 1'b1, 1'b0, 1'b0, 32'd4);
    chk("link", link_address, 32'hBFC00018);

    // Taken branch: delay slot then redirect.
    step("br1",   1'b1, 1'b0, 1'b1, 32'hBFC00100, 32'hBFC00014, 1'b1, 1'b1, 1'b1, 1'b0, 32'd5);
    step("redir", 1'b1, 1'b0, 1'b0, 32'h0,        32'hBFC00100, 1'b1, 1'b1, 1'b0, 1'b0, 32'd6);

    // Pause and stall while in the delay slot.
    step("br2", 1'b1, 1'b0, 1'b1, 32'hBFC00200, 32'hBFC00104, 1'b1, 1'b1, 1'b1, 1'b0, 32'd7);
    for (int i = 0; i < 5; i++)
      step("ce0", 1'b0, 1'b0, 1'b1, 32'hBFC00500, 32'hBFC00104, 1'b1, 1'b1, 1'b1, 1'b0, 32'd7);
    for (int i = 0; i < 3; i++)
      step("stl", 1'b1, 1'b1, 1'b1, 32'hBFC00500, 32'hBFC00104, 1'b1, 1'b1, 1'b1, 1'b0, 32'd7);
    step("rel",    1'b1, 1'b0, 1'b1, 32'hBFC00500, 32'hBFC00200, 1'b1, 1'b1, 1'b0, 1'b0, 32'd8);
    step("stlrun", 1'b1, 1'b1, 1'b0, 32'h0,        32'hBFC00200, 1'b1, 1'b1, 1'b0, 1'b0, 32'd8);
    step("run5",   1'b1, 1'b0, 1'b0, 32'h0,        32'hBFC00204, 1'b1, 1'b1, 1'b0, 1'b0, 32'd9);

    // Jump to HALT_ADDR: slot retires, then halt holds.
    step("jhalt", 1'b1, 1'b0, 1'b1, 32'h0, 32'hBFC00208, 1'b1, 1'b1, 1'b1, 1'b0, 32'd10);
    step("halt",  1'b1, 1'b0, 1'b0, 32'h0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd11);
    for (int i = 0; i < 10; i++)
      step("hold", 1'b1, 1'b0, logic'(i % 2), 32'hBFC00400, 32'h00000000,
           1'b0, 1'b0, 1'b0, 1'b0, 32'd11);

    // Asynchronous reset out of HALTED, then misaligned-target fault.
    #3 reset = 1'b0;
    #1 check_now("arst1", 32'hBFC00000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    #1 reset = 1'b1;
    step("boot2", 1'b1, 1'b0, 1'b0, 32'h0,        32'hBFC00000, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step("run6",  1'b1, 1'b0, 1'b0, 32'h0,        32'hBFC00004, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1);
    step("mis",   1'b1, 1'b0, 1'b1, 32'hBFC00102, 32'hBFC00004, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
    step("fhold", 1'b1, 1'b0, 1'b1, 32'hBFC00100, 32'hBFC00004, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);

    // Reset mid-SLOT discards the pending target.
    #3 reset = 1'b0;
    #1 check_now("arst2", 32'hBFC00000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    #1 reset = 1'b1;
    step("boot3", 1'b1, 1'b0, 1'b0, 32'h0,        32'hBFC00000, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step("br3",   1'b1, 1'b0, 1'b1, 32'hBFC00300, 32'hBFC00004, 1'b1, 1'b1, 1'b1, 1'b0, 32'd1);
    #3 reset = 1'b0;
    #1 check_now("arst3", 32'hBFC00000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    #1 reset = 1'b1;
    step("boot4", 1'b1, 1'b0, 1'b0, 32'h0, 32'hBFC00000, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step("nostale", 1'b1, 1'b0, 1'b0, 32'h0, 32'hBFC00004, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
